// File: rtl/core_dbus_arbiter.sv
// core_dbus_arbiter: N-requester data-port arbiter. It lets several cores or
// DMA engines share one peripheral target, using round-robin or fixed-priority
// arbitration. A watchdog ends a stalled access with an error response.
module core_dbus_arbiter #(
    parameter int                NUM_MASTERS = 2,
    parameter int                ADDR_W      = 64,
    parameter int                DATA_W      = 64,
    parameter int                STORE_W     = 2,
    parameter int                RR_MODE     = 1,
    parameter int                TIMEOUT     = 255,
    parameter logic [DATA_W-1:0] ERR_DATA    = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                                                 clock,
    input  logic                                                 reset,
    input  logic [NUM_MASTERS-1:0]                               m_valid,
    input  logic [NUM_MASTERS*ADDR_W-1:0]                        m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]                        m_wdata,
    input  logic [NUM_MASTERS*STORE_W-1:0]                       m_store_type,
    output logic [NUM_MASTERS-1:0]                               m_ready,
    output logic [NUM_MASTERS-1:0]                               m_err,
    output logic [DATA_W-1:0]                                    m_rdata,
    output logic [ADDR_W-1:0]                                    s_addr,
    output logic [DATA_W-1:0]                                    s_wdata,
    output logic [STORE_W-1:0]                                   s_store_type,
    output logic                                                 s_valid,
    input  logic                                                 s_ready,
    input  logic [DATA_W-1:0]                                    s_rdata,
    output logic [((NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1)-1:0] grant_id,
    output logic                                                 busy
);

    localparam int GID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [GID_W-1:0]   ptr;
    logic [GID_W-1:0]   win;
    logic [CNT_W-1:0]   cnt;
    logic               err_flag;
    logic               timeout_hit;
    int                 idx;
    logic               found;

    // Winner selection: scan upward from the pointer (round-robin) or from 0 (fixed).
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = (RR_MODE != 0) ? ((int'(ptr) + k) % NUM_MASTERS) : k;
            if (!found && m_valid[GID_W'(idx)]) begin
                found = 1'b1;
                win   = GID_W'(idx);
            end
        end
    end

    // Watchdog fires only when enabled and the wait counter has reached its limit.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one request in flight, RESP lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|m_valid) state_next = REQ;
            REQ:     if (s_ready || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner's request, capture the response, and advance the pointer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s_addr       <= '0;
            s_wdata      <= '0;
            s_store_type <= '0;
            grant_id     <= '0;
            m_rdata      <= '0;
            err_flag     <= 1'b0;
            cnt          <= '0;
            ptr          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_valid) begin
                        s_addr       <= m_addr[win*ADDR_W +: ADDR_W];
                        s_wdata      <= m_wdata[win*DATA_W +: DATA_W];
                        s_store_type <= m_store_type[win*STORE_W +: STORE_W];
                        grant_id     <= win;
                        cnt          <= '0;
                    end
                end
                REQ: begin
                    // A target response in the timeout cycle takes precedence.
                    if (s_ready) begin
                        m_rdata  <= s_rdata;
                        err_flag <= 1'b0;
                    end else if (timeout_hit) begin
                        m_rdata  <= ERR_DATA;
                        err_flag <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    ptr <= GID_W'((int'(grant_id) + 1) % NUM_MASTERS);
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decoded from state; completion is one-hot on the grantee.
    always_comb begin
        s_valid = (state == REQ);
        busy    = (state != IDLE);
        m_ready = (state == RESP) ? (ONE << grant_id) : '0;
        m_err   = ((state == RESP) && err_flag) ? (ONE << grant_id) : '0;
    end

endmodule

// File: tb/tb_core_dbus_arbiter.sv
// tb_core_dbus_arbiter: random and directed transactions checked against a
// transaction-level arbitration model. There are two arbiters, one round-robin
// and one fixed-priority, and they share every input.
module tb_core_dbus_arbiter;

    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = 2;
    localparam int TO = 4;
    localparam logic [63:0] ERRV = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [N-1:0]    m_valid = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N*SW-1:0] m_store_type = '0;
    logic            s_ready = 1'b0;
    logic [DW-1:0]   s_rdata = '0;

    logic [N-1:0] rr_m_ready, rr_m_err, fp_m_ready, fp_m_err;
    logic [DW-1:0] rr_m_rdata, fp_m_rdata, rr_s_wdata, fp_s_wdata;
    logic [AW-1:0] rr_s_addr, fp_s_addr;
    logic [SW-1:0] rr_s_store_type, fp_s_store_type;
    logic rr_s_valid, fp_s_valid, rr_busy, fp_busy;
    logic [0:0] rr_grant_id, fp_grant_id;

    int checks = 0;
    int errors = 0;
    int rr_ptr = 0;

    always #5 clock = ~clock;

    core_dbus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .STORE_W(SW),
                        .RR_MODE(1), .TIMEOUT(TO), .ERR_DATA(ERRV)) dut_rr (
        .clock(clock), .reset(reset), .m_valid(m_valid), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_store_type(m_store_type), .m_ready(rr_m_ready),
        .m_err(rr_m_err), .m_rdata(rr_m_rdata), .s_addr(rr_s_addr),
        .s_wdata(rr_s_wdata), .s_store_type(rr_s_store_type), .s_valid(rr_s_valid),
        .s_ready(s_ready), .s_rdata(s_rdata), .grant_id(rr_grant_id), .busy(rr_busy));

    core_dbus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .STORE_W(SW),
                        .RR_MODE(0), .TIMEOUT(TO), .ERR_DATA(ERRV)) dut_fp (
        .clock(clock), .reset(reset), .m_valid(m_valid), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_store_type(m_store_type), .m_ready(fp_m_ready),
        .m_err(fp_m_err), .m_rdata(fp_m_rdata), .s_addr(fp_s_addr),
        .s_wdata(fp_s_wdata), .s_store_type(fp_s_store_type), .s_valid(fp_s_valid),
        .s_ready(s_ready), .s_rdata(s_rdata), .grant_id(fp_grant_id), .busy(fp_busy));

    // Arbitration rule: first requester found scanning from ptr (wrapping) or from 0.
    function automatic int pick(input logic [N-1:0] v, input int ptr, input bit rr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = rr ? (ptr + k) % N : k;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic randomize_inputs();
        m_addr       = {$urandom, $urandom, $urandom, $urandom};
        m_wdata      = {$urandom, $urandom, $urandom, $urandom};
        m_store_type = (N*SW)'($urandom);
    endtask

    // One complete transaction. The target answers in REQ cycle d; it never answers if d > TO.
    task automatic run_txn(input logic [N-1:0] v, input int d, input bit wiggle,
                           input logic [DW-1:0] rd, output int got_rr, output int got_fp);
        int grr, gfp, nreq;
        bit err;
        logic [AW-1:0] ea_rr, ea_fp;
        logic [DW-1:0] ew_rr, ew_fp, exp_rd;
        logic [SW-1:0] es_rr, es_fp;
        logic [N-1:0] oh_rr, oh_fp;
        grr = pick(v, rr_ptr, 1'b1);
        gfp = pick(v, 0, 1'b0);
        ea_rr = m_addr[grr*AW +: AW];   ea_fp = m_addr[gfp*AW +: AW];
        ew_rr = m_wdata[grr*DW +: DW];  ew_fp = m_wdata[gfp*DW +: DW];
        es_rr = m_store_type[grr*SW +: SW]; es_fp = m_store_type[gfp*SW +: SW];
        err = (d > TO);
        nreq = err ? TO + 1 : d + 1;
        exp_rd = err ? ERRV : rd;
        oh_rr = '0; oh_rr[grr] = 1'b1;
        oh_fp = '0; oh_fp[gfp] = 1'b1;
        got_rr = -1; got_fp = -1;
        m_valid = v;
        for (int j = 0; j < nreq; j++) begin
            @(negedge clock);
            if (j == 0) begin got_rr = int'(rr_grant_id); got_fp = int'(fp_grant_id); end
            checks++;
            if (rr_s_valid !== 1'b1 || fp_s_valid !== 1'b1 || rr_busy !== 1'b1 || fp_busy !== 1'b1)
                begin errors++; $display("FAIL req_valid cyc%0d s_valid=%b/%b busy=%b/%b want 1", j, rr_s_valid, fp_s_valid, rr_busy, fp_busy); end
            checks++;
            if (rr_s_addr !== ea_rr || rr_s_wdata !== ew_rr || rr_s_store_type !== es_rr || int'(rr_grant_id) != grr)
                begin errors++; $display("FAIL rr_latch cyc%0d addr=%h gid=%0d want addr=%h gid=%0d", j, rr_s_addr, rr_grant_id, ea_rr, grr); end
            checks++;
            if (fp_s_addr !== ea_fp || fp_s_wdata !== ew_fp || fp_s_store_type !== es_fp || int'(fp_grant_id) != gfp)
                begin errors++; $display("FAIL fp_latch cyc%0d addr=%h gid=%0d want addr=%h gid=%0d", j, fp_s_addr, fp_grant_id, ea_fp, gfp); end
            if (wiggle) begin
                randomize_inputs();
                if (j == 0) m_addr = '0;
                m_valid = N'($urandom);
            end
            s_ready = (j == d);
            s_rdata = (j == d) ? rd : {$urandom, $urandom};
        end
        @(negedge clock);
        s_ready = 1'b0;
        s_rdata = {$urandom, $urandom};
        checks++;
        if (rr_m_ready !== oh_rr || rr_m_err !== (err ? oh_rr : '0) || rr_m_rdata !== exp_rd)
            begin errors++; $display("FAIL rr_resp rdy=%b err=%b rdata=%h want rdy=%b err=%b rdata=%h", rr_m_ready, rr_m_err, rr_m_rdata, oh_rr, err ? oh_rr : '0, exp_rd); end
        checks++;
        if (fp_m_ready !== oh_fp || fp_m_err !== (err ? oh_fp : '0) || fp_m_rdata !== exp_rd)
            begin errors++; $display("FAIL fp_resp rdy=%b err=%b rdata=%h want rdy=%b err=%b rdata=%h", fp_m_ready, fp_m_err, fp_m_rdata, oh_fp, err ? oh_fp : '0, exp_rd); end
        checks++;
        if (rr_s_valid !== 1'b0 || fp_s_valid !== 1'b0 || rr_busy !== 1'b1 || fp_busy !== 1'b1)
            begin errors++; $display("FAIL resp_state s_valid=%b/%b busy=%b/%b want 0/1", rr_s_valid, fp_s_valid, rr_busy, fp_busy); end
        rr_ptr = (grr + 1) % N;
        m_valid = v;
        @(negedge clock);
        checks++;
        if (rr_s_valid !== 1'b0 || rr_busy !== 1'b0 || rr_m_ready !== '0 || fp_m_ready !== '0 || rr_s_addr !== ea_rr)
            begin errors++; $display("FAIL idle_after s_valid=%b busy=%b rdy=%b/%b addr=%h want 0 0 0 addr=%h", rr_s_valid, rr_busy, rr_m_ready, fp_m_ready, rr_s_addr, ea_rr); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m_valid = '1;
        s_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({rr_m_ready, rr_m_err, rr_s_valid, rr_busy, rr_grant_id, fp_m_ready, fp_s_valid, fp_busy} !== '0)
            begin errors++; $display("FAIL reset_ctrl rdy=%b err=%b sv=%b busy=%b gid=%b want 0", rr_m_ready, rr_m_err, rr_s_valid, rr_busy, rr_grant_id); end
        checks++;
        if (rr_s_addr !== '0 || rr_s_wdata !== '0 || rr_s_store_type !== '0 || rr_m_rdata !== '0 || fp_s_addr !== '0)
            begin errors++; $display("FAIL reset_data addr=%h wdata=%h rdata=%h want 0", rr_s_addr, rr_s_wdata, rr_m_rdata); end
        m_valid = '0;
        s_ready = 1'b0;
        reset = 1'b1;
        rr_ptr = 0;
        @(negedge clock);
    endtask

    task automatic test_round_robin();
        int grr, gfp;
        for (int k = 0; k < 4; k++) begin
            randomize_inputs();
            run_txn(2'b11, 0, 1'b0, {$urandom, $urandom}, grr, gfp);
            checks++;
            if (grr != (k % 2) || gfp != 0)
                begin errors++; $display("FAIL rr_sequence txn%0d rr=%0d fp=%0d want rr=%0d fp=0", k, grr, gfp, k % 2); end
        end
    endtask

    task automatic test_single();
        int grr, gfp;
        randomize_inputs();
        m_addr[0 +: AW] = 64'h2000_0010;
        m_store_type[0 +: SW] = '0;
        run_txn(2'b01, 0, 1'b0, 64'h1234, grr, gfp);
        checks++;
        if (rr_s_addr !== 64'h2000_0010 || rr_m_rdata !== 64'h1234 || grr != 0)
            begin errors++; $display("FAIL single addr=%h rdata=%h gid=%0d want 2000_0010 1234 0", rr_s_addr, rr_m_rdata, grr); end
        m_valid = '0;
    endtask

    task automatic test_stability();
        int grr, gfp;
        randomize_inputs();
        m_addr[0 +: AW] = 64'h2000_0010;
        run_txn(2'b01, 3, 1'b1, {$urandom, $urandom}, grr, gfp);
        checks++;
        if (rr_s_addr !== 64'h2000_0010 || fp_s_addr !== 64'h2000_0010)
            begin errors++; $display("FAIL stability addr=%h/%h want 2000_0010", rr_s_addr, fp_s_addr); end
        m_valid = '0;
    endtask

    task automatic test_timeout();
        int grr, gfp;
        randomize_inputs();
        run_txn(2'b10, 100, 1'b0, '0, grr, gfp);
        checks++;
        if (rr_m_rdata !== ERRV)
            begin errors++; $display("FAIL timeout_data rdata=%h want %h", rr_m_rdata, ERRV); end
        randomize_inputs();
        run_txn(2'b01, TO, 1'b0, 64'h0BAD_F00D_5555_AAAA, grr, gfp);
        checks++;
        if (rr_m_rdata !== 64'h0BAD_F00D_5555_AAAA)
            begin errors++; $display("FAIL timeout_race rdata=%h want 0badf00d5555aaaa", rr_m_rdata); end
        m_valid = '0;
    endtask

    task automatic test_idle();
        logic [AW-1:0] held;
        held = rr_s_addr;
        m_valid = '0;
        for (int k = 0; k < 3; k++) begin
            s_ready = 1'b1;
            randomize_inputs();
            @(negedge clock);
            checks++;
            if (rr_s_valid !== 1'b0 || rr_busy !== 1'b0 || rr_m_ready !== '0 || fp_m_ready !== '0 || rr_s_addr !== held)
                begin errors++; $display("FAIL idle_hold sv=%b busy=%b rdy=%b addr=%h want 0 0 0 %h", rr_s_valid, rr_busy, rr_m_ready, rr_s_addr, held); end
        end
        s_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int grr, gfp;
        randomize_inputs();
        m_valid = 2'b10;
        @(negedge clock);
        checks++;
        if (rr_s_valid !== 1'b1 || rr_grant_id !== 1'b1)
            begin errors++; $display("FAIL mid_enter sv=%b gid=%b want 1 1", rr_s_valid, rr_grant_id); end
        reset = 1'b0;
        m_valid = 2'b11;
        s_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (rr_s_valid !== 1'b0 || rr_busy !== 1'b0 || rr_m_ready !== '0 || rr_grant_id !== 1'b0 || fp_s_valid !== 1'b0 || fp_m_ready !== '0)
            begin errors++; $display("FAIL mid_reset sv=%b busy=%b rdy=%b gid=%b want 0", rr_s_valid, rr_busy, rr_m_ready, rr_grant_id); end
        reset = 1'b1;
        s_ready = 1'b0;
        rr_ptr = 0;
        run_txn(2'b11, 1, 1'b0, {$urandom, $urandom}, grr, gfp);
        checks++;
        if (grr != 0)
            begin errors++; $display("FAIL mid_rearb gid=%0d want 0", grr); end
        m_valid = '0;
    endtask

    task automatic test_random();
        int grr, gfp;
        for (int k = 0; k < 30; k++) begin
            randomize_inputs();
            run_txn(N'($urandom_range(1, 3)), int'($urandom_range(0, 6)), 1'($urandom),
                    {$urandom, $urandom}, grr, gfp);
            if ($urandom_range(0, 2) == 0) begin
                m_valid = '0;
                @(negedge clock);
            end
        end
        m_valid = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        m_valid = '0;
        @(negedge clock);
        test_single();
        test_stability();
        test_timeout();
        test_idle();
        test_reset_mid();
        @(negedge clock);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_dbus_arbiter.md
Name: core_dbus_arbiter

Overview:
- Parametrised N-requester data-port arbiter. Generalises the core's single d_addr/d_wdata/d_rdata/d_store_type/d_valid/d_ready peripheral port so that several cores or DMA engines share one peripheral target.
- Provides selectable round-robin or fixed-priority arbitration, configurable address and data widths, and a bus-timeout watchdog that returns an error response.
- Sits between the requesters' data ports and the peripheral interconnect at PERIPHERAL_BASE.

Parameters:
- NUM_MASTERS, 2, number of requesters N (1..16).
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- STORE_W, 2, width of one mem_store_type_t field; value 0 means load/no store.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority with lowest index winning.
- TIMEOUT, 255, maximum wait cycles for s_ready; 0 disables the watchdog.
- ERR_DATA, 64'hDEAD_BEEF_DEAD_BEEF, value returned on m_rdata when a timeout occurs.

Ports:
- clock  in  1  sole clock; rising edge.
- reset  in  1  synchronous, active-low reset: reset==0 at a rising clock edge resets the block.
- m_valid  in  N  per-requester request.
- m_addr  in  N*ADDR_W  packed; requester i occupies [i*ADDR_W +: ADDR_W].
- m_wdata  in  N*DATA_W  packed write data.
- m_store_type  in  N*STORE_W  packed store type.
- m_ready  out  N  one-hot completion pulse.
- m_err  out  N  one-hot timeout error, qualified by m_ready.
- m_rdata  out  DATA_W  shared read data, valid with any m_ready bit.
- s_addr  out  ADDR_W  latched address to target.
- s_wdata  out  DATA_W  latched write data.
- s_store_type  out  STORE_W  latched store type.
- s_valid  out  1  request to target.
- s_ready  in  1  target completion.
- s_rdata  in  DATA_W  target read data, valid with s_ready.
- grant_id  out  $clog2(N) (min 1)  index of current or last grantee.
- busy  out  1  high in REQ and RESP.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; timeout counter 0. Reset mid-transaction abandons it: s_valid drops on the next edge and no m_ready is issued.
- State IDLE:
  - If any m_valid bit is set, pick a winner g:
    - RR_MODE=1: first set bit searching upward from the pointer, wrapping N-1 -> 0.
    - RR_MODE=0: lowest set index.
  - On that edge, latch m_addr/m_wdata/m_store_type of g into the s_* outputs, set grant_id=g, clear the counter, and go to REQ.
  - No request: stay in IDLE; s_* outputs hold their last values; s_valid=0.
- State REQ:
  - s_valid=1, and all s_* outputs are stable for the whole state.
  - Requester inputs are ignored; a change on m_* while in REQ has no effect.
  - s_ready=1: capture s_rdata into m_rdata, m_err=0, go to RESP.
  - Otherwise, with TIMEOUT!=0, increment the counter. When the counter equals TIMEOUT with s_ready=0, load m_rdata=ERR_DATA and set m_err[g]=1, then go to RESP.
  - s_ready wins if it coincides with the timeout cycle.
- State RESP, exactly 1 cycle:
  - s_valid=0; m_ready[g]=1 with m_rdata/m_err valid.
  - Pointer = (g+1) mod N. Next state is IDLE.
  - m_valid is ignored in RESP. A requester still asserting m_valid in the following IDLE cycle starts a new transaction.
- Latency:
  - Request seen in IDLE at edge t: s_valid high in cycle t+1.
  - s_ready at edge k: m_ready pulse in cycle k+1.
  - Minimum 3 cycles per transaction (s_ready in the first REQ cycle); at most one outstanding transaction.
- Stores and loads follow the same path; m_rdata on a store completion is whatever s_rdata carried.
- s_ready is ignored outside REQ.
- N=1: the arbiter degenerates to a registered pass-through with the same timing; grant_id is constant 0.
- m_ready and m_err are one-hot or zero. m_err is never set without m_ready.

Test Plan:
- Single request:
  - Stimulus: N=2, m_valid=2'b01, m_addr[0]=64'h2000_0010, store_type=0, s_ready high on the first REQ cycle with s_rdata=64'h1234.
  - Required: s_valid for 1 cycle with s_addr=64'h2000_0010, then m_ready=2'b01 with m_rdata=64'h1234 three cycles after the request.
- Round-robin:
  - Stimulus: both m_valid held high continuously; target responds immediately.
  - Required: grant sequence 0,1,0,1; m_ready alternates 01,10,01,10; no starvation.
- Fixed priority:
  - Stimulus: RR_MODE=0, both requesting.
  - Required: requester 0 is granted every transaction and requester 1 is never granted.
- Timeout:
  - Stimulus: TIMEOUT=4, s_ready held 0.
  - Required: s_valid high for 5 cycles, then m_ready[g]=1, m_err[g]=1, m_rdata=64'hDEADBEEFDEADBEEF.
  - Also: s_ready arriving in the timeout cycle gives m_err=0 with the target's data.
- Stability:
  - Stimulus: change m_addr[0] to 64'h0 during REQ.
  - Required: s_addr remains 64'h2000_0010 until completion.
- Reset mid-operation:
  - Stimulus: reset=0 for 1 edge while in REQ.
  - Required: s_valid=0, busy=0, m_ready=0, grant_id=0 next cycle; with reset=1, a pending request is re-arbitrated from pointer 0.
